traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Phase sequencer for a two-road intersection. Divides the system clock to a 1 s tick. Steps main/side signal heads through green, yellow and red phases, and produces the 6-bit remaining-seconds value for the display stage downstream. The `count` output feeds that display stage directly. The light outputs drive the signal heads.

## Interface
Parameters:
- `TICK_DIV`, default 50000000: clock cycles per 1 s tick. Minimum 2.
- `MAIN_GREEN`, default 40: main-road green duration in ticks. Range 1..63.
- `SIDE_GREEN`, default 25: side-road green duration in ticks. Range 1..63.
- `YELLOW`, default 5: yellow duration in ticks, both roads. Range 1..63.
- `PED_MIN`, default 10: remaining main-green after a pedestrian request. Range 1..63.

Ports:
- `clk` in 1: system clock. The block has one clock; everything is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ped_req` in 1: pedestrian crossing request, synchronous, level-sampled.
- `night` in 1: night mode select, synchronous level.
- `count` out 6: remaining seconds of the current phase. Unsigned binary.
- `main_light` out 3: main-road head, {R,Y,G}, one-hot or 000.
- `side_light` out 3: side-road head, {R,Y,G}, one-hot or 000.
- `tick` out 1: one-cycle pulse every `TICK_DIV` cycles.

## Operation
- **Prescaler:** `div` counts 0..`TICK_DIV`-1 and wraps.
  - `tick` is registered. It is 1 exactly in the cycle after `div`==`TICK_DIV`-1.
  - The prescaler is free-running and is never reset by the FSM.
- **States:** MG, MY, SG, SY, NIGHT.
  - MG: main 001, side 100.
  - MY: main 010, side 100.
  - SG: main 100, side 001.
  - SY: main 100, side 010.
  - NIGHT: both heads flash 010 / 000.
- **Phase entry:** `count` loads the phase duration on entry.
  - MG loads `MAIN_GREEN`, MY loads `YELLOW`, SG loads `SIDE_GREEN`, SY loads `YELLOW`.
  - NIGHT holds `count`=0.
- **On each `tick`, normal states:**
  - If `count`>1, `count` decrements.
  - If `count`==1, advance MG→MY→SG→SY→MG and load the next duration. The displayed sequence is therefore N..1; 0 is never shown outside NIGHT.
- **Pedestrian request:** `ped_req`=1 while in MG with `count`>`PED_MIN` loads `count`←`PED_MIN` on the next edge.
  - This takes priority over a simultaneous tick decrement.
  - `ped_req` is ignored in every other state, and in MG when `count`≤`PED_MIN`.
  - Requests are not latched.
- **Entering night mode:** `night`=1 sampled on a tick in any normal state → NIGHT. Both heads go 010 and `count`=0.
  - `night` takes priority over a phase-end advance on the same tick.
- **In NIGHT:**
  - Each tick toggles both heads between 010 and 000.
  - A tick with `night`=0 → MG with `count`=`MAIN_GREEN`.
- `night` changes between ticks have no effect until the next tick.
- Both heads are never green or yellow at the same time outside NIGHT.

## Timing
- **Reset (async, `rst`=0):**
  - State MG, `count`=`MAIN_GREEN`, `main_light`=001, `side_light`=100.
  - `tick`=0, `div`=0, flash phase = on.
  - Reset takes effect immediately, including mid-phase and mid-NIGHT.
- **First tick:** after `rst` rises, the first `tick` pulse occurs on the `TICK_DIV`-th rising edge after release. Subsequent pulses follow every `TICK_DIV` cycles.
- **Update latency:** state, `count` and lights update on the edge that samples `tick`=1, so they change 1 cycle after the `tick` pulse rises.
- **`ped_req` latency:** 1 cycle from sample to `count` update.
- **Registered outputs:** all outputs are registered; no combinational path from input to output.

## Test plan
Use `TICK_DIV`=4 and default durations.

1. **Reset and first tick.** Release `rst` → `count`=40, main 001, side 100, `tick` pulse on the 4th edge after release, `count`=39 one cycle later.
2. **Full cycle.** Run ticks with `night`=`ped_req`=0:
   - MG shows 40..1, then MY 5..1, SG 25..1, SY 5..1, then MG 40.
   - Lights at each transition match the state encoding.
   - Total period is 75 ticks.
3. **Pedestrian request.**
   - Pulse `ped_req` in MG at `count`=30 → `count`=10 next cycle, with no decrement that cycle.
   - At `count`=8 → no effect.
   - In SG at any count → no effect.
4. **Night mode.**
   - Assert `night` mid-SG (`count`=12) → at the next tick: NIGHT, `count`=0, lights 010/010.
   - Following ticks: 000/000, then 010/010.
   - Deassert `night` → at the next tick: MG, `count`=40.
5. **Night priority.** Assert `night` so it is sampled on the tick where SY `count`==1 → NIGHT, not MG.
6. **Reset mid-operation.** Assert `rst` during MY with `count`=3 and `div`=2 → outputs return to reset values immediately. After release, the first tick arrives 4 edges later.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection phase sequencer: 1 s prescaler, MG/MY/SG/SY cycle,
// pedestrian shortening of main green, and a flashing-yellow night mode.
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned MAIN_GREEN = 40,
  parameter int unsigned SIDE_GREEN = 25,
  parameter int unsigned YELLOW     = 5,
  parameter int unsigned PED_MIN    = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ped_req,
  input  logic       night,
  output logic [5:0] count,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       tick
);

  localparam int unsigned     DivW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);

  localparam logic [5:0] MainGreenCnt = 6'(MAIN_GREEN);
  localparam logic [5:0] SideGreenCnt = 6'(SIDE_GREEN);
  localparam logic [5:0] YellowCnt    = 6'(YELLOW);
  localparam logic [5:0] PedCnt       = 6'(PED_MIN);

  localparam logic [2:0] LtRed = 3'b100;
  localparam logic [2:0] LtYel = 3'b010;
  localparam logic [2:0] LtGrn = 3'b001;
  localparam logic [2:0] LtOff = 3'b000;

  typedef enum logic [2:0] {
    StMg,
    StMy,
    StSg,
    StSy,
    StNight
  } state_e;

  state_e          state_q, state_d;
  logic [5:0]      count_q, count_d;
  logic            flash_q, flash_d;
  logic [2:0]      main_q, main_d;
  logic [2:0]      side_q, side_d;
  logic [DivW-1:0] div_q;
  logic            tick_q;

  // Free-running prescaler; the FSM never restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (div_q == DivMax);
      div_q  <= (div_q == DivMax) ? '0 : div_q + DivW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    flash_d = flash_q;

    if (tick_q && (state_q == StNight)) begin
      if (night) begin
        flash_d = ~flash_q;
      end else begin
        state_d = StMg;
        count_d = MainGreenCnt;
        flash_d = 1'b1;
      end
    end else if (tick_q && night) begin
      // Night wins over a phase-end advance on the same tick.
      state_d = StNight;
      count_d = '0;
      flash_d = 1'b1;
    end else if (ped_req && (state_q == StMg) && (count_q > PedCnt)) begin
      count_d = PedCnt;
    end else if (tick_q) begin
      if (count_q > 6'd1) begin
        count_d = count_q - 6'd1;
      end else begin
        unique case (state_q)
          StMg: begin
            state_d = StMy;
            count_d = YellowCnt;
          end
          StMy: begin
            state_d = StSg;
            count_d = SideGreenCnt;
          end
          StSg: begin
            state_d = StSy;
            count_d = YellowCnt;
          end
          default: begin
            state_d = StMg;
            count_d = MainGreenCnt;
          end
        endcase
      end
    end
  end

  // Lights are decoded from the next state so they register alongside it.
  always_comb begin
    main_d = LtRed;
    side_d = LtRed;
    unique case (state_d)
      StMg: begin
        main_d = LtGrn;
        side_d = LtRed;
      end
      StMy: begin
        main_d = LtYel;
        side_d = LtRed;
      end
      StSg: begin
        main_d = LtRed;
        side_d = LtGrn;
      end
      StSy: begin
        main_d = LtRed;
        side_d = LtYel;
      end
      StNight: begin
        main_d = flash_d ? LtYel : LtOff;
        side_d = flash_d ? LtYel : LtOff;
      end
      default: begin
        main_d = LtRed;
        side_d = LtRed;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StMg;
      count_q <= MainGreenCnt;
      flash_q <= 1'b1;
      main_q  <= LtGrn;
      side_q  <= LtRed;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      flash_q <= flash_d;
      main_q  <= main_d;
      side_q  <= side_d;
    end
  end

  assign count      = count_q;
  assign main_light = main_q;
  assign side_light = side_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed scenarios with literal expectations,
// then randomized stimulus, all outputs compared every cycle to a phase-table model.
module tb_traffic_light_ctrl;

  localparam int TD = 4;

  logic       clk;
  logic       rst;
  logic       ped_req;
  logic       night;
  logic [5:0] count;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       tick;

  int checks;
  int errors;

  // Model: phase index into duration/light tables, or night mode.
  int   m_div;
  int   m_ph;
  int   m_count;
  bit   m_tick;
  bit   m_nm;
  bit   m_flash;
  int   dur[4]            = '{40, 5, 25, 5};
  logic [2:0] main_tab[4] = '{3'b001, 3'b010, 3'b100, 3'b100};
  logic [2:0] side_tab[4] = '{3'b100, 3'b100, 3'b001, 3'b010};

  int lit_tick[5] = '{39, 40, 45, 70, 75};
  int lit_cnt[5]  = '{1, 5, 25, 5, 40};
  int lit_main[5] = '{1, 2, 4, 4, 1};
  int lit_side[5] = '{4, 4, 1, 2, 4};

  traffic_light_ctrl #(
    .TICK_DIV(TD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ped_req   (ped_req),
    .night     (night),
    .count     (count),
    .main_light(main_light),
    .side_light(side_light),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_div   = 0;
    m_tick  = 0;
    m_nm    = 0;
    m_ph    = 0;
    m_count = 40;
    m_flash = 1;
  endtask

  task automatic model_step();
    bit t;
    t      = m_tick;
    m_tick = (m_div == TD - 1);
    m_div  = (m_div + 1) % TD;
    if (m_nm) begin
      if (t) begin
        if (night) m_flash = !m_flash;
        else begin
          m_nm    = 0;
          m_ph    = 0;
          m_count = dur[0];
        end
      end
    end else if (t && night) begin
      m_nm    = 1;
      m_count = 0;
      m_flash = 1;
    end else if (ped_req && m_ph == 0 && m_count > 10) begin
      m_count = 10;
    end else if (t) begin
      if (m_count > 1) m_count--;
      else begin
        m_ph    = (m_ph + 1) % 4;
        m_count = dur[m_ph];
      end
    end
  endtask

  function automatic logic [2:0] exp_main();
    if (m_nm) return m_flash ? 3'b010 : 3'b000;
    return main_tab[m_ph];
  endfunction

  function automatic logic [2:0] exp_side();
    if (m_nm) return m_flash ? 3'b010 : 3'b000;
    return side_tab[m_ph];
  endfunction

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    if (rst) model_step();
    else model_reset();
    @(negedge clk);
    chk("count", int'(count), m_count);
    chk("main_light", int'(main_light), int'(exp_main()));
    chk("side_light", int'(side_light), int'(exp_side()));
    chk("tick", int'(tick), int'(m_tick));
  endtask

  task automatic goto_phase(input string name, input int ph, input int cnt,
                            input int want_tick, input int want_div);
    int n;
    n = 0;
    while (!(!m_nm && m_ph == ph && m_count == cnt &&
             (want_tick < 0 || int'(m_tick) == want_tick) &&
             (want_div < 0 || m_div == want_div)) && n < 2000) begin
      cyc();
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL goto_%s: got timeout expected phase %0d count %0d", name, ph, cnt);
    end
  endtask

  task automatic chk_lit(input string name, input int c, input int m, input int s);
    chk({name, "_count"}, int'(count), c);
    chk({name, "_main"}, int'(main_light), m);
    chk({name, "_side"}, int'(side_light), s);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    ped_req = 1'b0;
    night   = 1'b0;
    model_reset();
    repeat (3) cyc();

    // Reset values and first tick
    chk_lit("reset", 40, 1, 4);
    chk("reset_tick", int'(tick), 0);
    chk("model_reset_count", m_count, 40);
    rst = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("first_tick", int'(tick), (i == 4) ? 1 : 0);
    end
    chk("first_dec_count", int'(count), 39);
    chk("model_first_dec", m_count, 39);

    // Full cycle: 75 ticks back to MG 40
    for (int k = 2; k <= 75; k++) begin
      repeat (TD) cyc();
      for (int j = 0; j < 5; j++)
        if (lit_tick[j] == k) chk_lit("cycle", lit_cnt[j], lit_main[j], lit_side[j]);
    end

    // Pedestrian request coinciding with a tick at count 30
    goto_phase("mg30", 0, 30, 1, -1);
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    chk("ped_load", int'(count), 10);
    goto_phase("mg8", 0, 8, 1, -1);
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    chk("ped_low_ignored", int'(count), 7);
    goto_phase("sg20", 2, 20, 0, -1);
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    chk_lit("ped_sg_ignored", 20, 4, 1);

    // Night entry mid-SG, flashing, exit
    goto_phase("sg12", 2, 12, -1, -1);
    night = 1'b1;
    repeat (TD) cyc();
    chk_lit("night_enter", 0, 2, 2);
    repeat (TD) cyc();
    chk_lit("night_off", 0, 0, 0);
    repeat (TD) cyc();
    chk_lit("night_on", 0, 2, 2);
    night = 1'b0;
    repeat (TD) cyc();
    chk_lit("night_exit", 40, 1, 4);

    // Night beats the SY phase-end advance
    goto_phase("sy1", 3, 1, -1, -1);
    night = 1'b1;
    repeat (TD) cyc();
    chk_lit("night_prio", 0, 2, 2);
    night = 1'b0;
    repeat (TD) cyc();
    chk_lit("night_prio_exit", 40, 1, 4);

    // Asynchronous reset mid-MY
    goto_phase("my3", 1, 3, -1, 2);
    rst = 1'b0;
    model_reset();
    #1;
    chk_lit("async_reset", 40, 1, 4);
    chk("async_reset_tick", int'(tick), 0);
    cyc();
    rst = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("rerelease_tick", int'(tick), (i == 4) ? 1 : 0);
    end

    // Randomized stimulus
    for (int i = 0; i < 6000; i++) begin
      cyc();
      ped_req = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) night = ~night;
      if ($urandom_range(0, 1999) == 0) begin
        rst = 1'b0;
        model_reset();
        cyc();
        rst = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
